// File: rtl/inst_mem_banked_if.sv
// Fetch and load bus of the banked instruction memory.
// The processor fetch path and the program loader use the master side; the memory uses the slave side.
interface inst_mem_banked_if #(
    parameter int unsigned INST_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BANK_W = 1
);
    logic              fetch_req_i;
    logic [BANK_W-1:0] bank_sel_i;
    logic [ADDR_W-1:0] address_i;
    logic [INST_W-1:0] instruction_o;
    logic              inst_valid_o;
    logic              load_en_i;
    logic [BANK_W-1:0] load_bank_i;
    logic [ADDR_W-1:0] load_addr_i;
    logic [INST_W-1:0] load_data_i;
    logic              load_err_o;
    logic              ready_o;

    modport master (
        output fetch_req_i, bank_sel_i, address_i,
        output load_en_i, load_bank_i, load_addr_i, load_data_i,
        input  instruction_o, inst_valid_o, load_err_o, ready_o
    );

    modport slave (
        input  fetch_req_i, bank_sel_i, address_i,
        input  load_en_i, load_bank_i, load_addr_i, load_data_i,
        output instruction_o, inst_valid_o, load_err_o, ready_o
    );
endinterface

// File: rtl/inst_mem_banked.sv
// Loadable multi-bank instruction memory with registered fetch.
// After reset every word is overwritten with HALT_INST, one index per cycle across all banks.
module inst_mem_banked #(
    parameter int unsigned       INST_W    = 8,
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DEPTH     = 256,
    parameter int unsigned       NUM_BANKS = 2,
    parameter int unsigned       BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter logic [INST_W-1:0] HALT_INST = INST_W'(8'b11100000)
) (
    input logic              clk_i,
    input logic              rst_n_i,
    inst_mem_banked_if.slave bus
);
    localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [BANK_W:0]  BANKS_L  = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR,
        S_READY
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_clr_idx;
    logic [INST_W-1:0] r_inst;
    logic              r_valid;
    logic              r_load_err;

    logic              w_fetch_in_range;
    logic              w_load_in_range;
    logic              w_fetch_ok;
    logic              w_load_ok;
    logic [IDX_W-1:0]  w_fetch_idx;
    logic [IDX_W-1:0]  w_load_idx;
    logic [INST_W-1:0] w_bank_rd [NUM_BANKS];

    // Range checks use the full address and bank width so nothing aliases.
    assign w_fetch_in_range = ({1'b0, bus.address_i} < DEPTH_L) &&
                              ({1'b0, bus.bank_sel_i} < BANKS_L);
    assign w_load_in_range  = ({1'b0, bus.load_addr_i} < DEPTH_L) &&
                              ({1'b0, bus.load_bank_i} < BANKS_L);
    assign w_fetch_ok  = bus.fetch_req_i && (r_state == S_READY);
    assign w_load_ok   = bus.load_en_i && w_load_in_range && (r_state == S_READY);
    assign w_fetch_idx = bus.address_i[IDX_W-1:0];
    assign w_load_idx  = bus.load_addr_i[IDX_W-1:0];

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n_i) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_CLEAR) begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: the default assignment first keeps this block free of inferred latches.
        w_state_next = r_state;
        if ((r_state == S_CLEAR) && (r_clr_idx == LAST_IDX)) begin
            w_state_next = S_READY;
        end
    end

    // One write port per bank, shared between the clear sweep and the loader.
    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        logic [INST_W-1:0] r_bank [DEPTH];

        always_ff @(posedge clk_i) begin
            // NOTE: the array has no reset branch; the CLEAR sweep initialises it instead.
            if (rst_n_i) begin
                if (r_state == S_CLEAR) begin
                    r_bank[r_clr_idx] <= HALT_INST;
                end else if (w_load_ok && (bus.load_bank_i == BANK_W'(gb))) begin
                    r_bank[w_load_idx] <= bus.load_data_i;
                end
            end
        end

        assign w_bank_rd[gb] = r_bank[w_fetch_idx];
    end

    // The read samples the array before any same-edge load lands, giving read-first behaviour.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_inst     <= HALT_INST;
            r_valid    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_valid    <= w_fetch_ok;
            r_load_err <= bus.load_en_i && !w_load_ok;
            if (w_fetch_ok) begin
                r_inst <= w_fetch_in_range ? w_bank_rd[bus.bank_sel_i] : HALT_INST;
            end
        end
    end

    assign bus.instruction_o = r_inst;
    assign bus.inst_valid_o  = r_valid;
    assign bus.load_err_o    = r_load_err;
    assign bus.ready_o       = (r_state == S_READY);
endmodule

// File: tb/tb_inst_mem_banked.sv
// Scoreboard bench for inst_mem_banked: a default 256x2 instance and a 96x3 instance for range edges.
// Stimulus tasks queue expected fetch results and load errors; negedge monitors pop and compare.
module tb_inst_mem_banked;
    localparam logic [7:0] HALT = 8'b11100000;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cycle_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t qa[$];
    exp_t qb[$];
    int   ea[$];
    int   eb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    inst_mem_banked_if #(.INST_W(8), .ADDR_W(8), .BANK_W(1)) ifa ();
    inst_mem_banked_if #(.INST_W(8), .ADDR_W(8), .BANK_W(2)) ifb ();

    inst_mem_banked #(
        .INST_W(8), .ADDR_W(8), .DEPTH(256), .NUM_BANKS(2), .BANK_W(1), .HALT_INST(HALT)
    ) dut_a (
        .clk_i  (clk),
        .rst_n_i(rst_a),
        .bus    (ifa.slave)
    );

    inst_mem_banked #(
        .INST_W(8), .ADDR_W(8), .DEPTH(96), .NUM_BANKS(3), .BANK_W(2), .HALT_INST(HALT)
    ) dut_b (
        .clk_i  (clk),
        .rst_n_i(rst_b),
        .bus    (ifb.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    // ---------------- DUT A stimulus ----------------
    task automatic drive_a(input bit fe, input logic [0:0] fb, input logic [7:0] fa,
                           input bit le, input logic [0:0] lb, input logic [7:0] la,
                           input logic [7:0] ld, input bit xv, input logic [7:0] xd, input bit xe);
        exp_t e;
        ifa.fetch_req_i = fe;
        ifa.bank_sel_i  = fb;
        ifa.address_i   = fa;
        ifa.load_en_i   = le;
        ifa.load_bank_i = lb;
        ifa.load_addr_i = la;
        ifa.load_data_i = ld;
        if (xv) begin
            e.data = xd;
            e.cyc  = cycle_cnt + 1;
            qa.push_back(e);
        end
        if (xe) ea.push_back(cycle_cnt + 1);
        @(posedge clk);
        #1;
        ifa.fetch_req_i = 1'b0;
        ifa.load_en_i   = 1'b0;
    endtask

    task automatic idle_a();
        drive_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic fetch_a(input logic [0:0] b, input logic [7:0] a, input logic [7:0] xd);
        drive_a(1'b1, b, a, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, xd, 1'b0);
    endtask

    task automatic load_a(input logic [0:0] b, input logic [7:0] a, input logic [7:0] d, input bit xe);
        drive_a(1'b0, 1'b0, 8'h00, 1'b1, b, a, d, 1'b0, 8'h00, xe);
    endtask

    // Fetches bank 0 address 0 every cycle through CLEAR (none may be answered) and counts edges to ready.
    task automatic wait_ready_a(input int exp_edges, input int err_at);
        int n = 0;
        for (int i = 1; i <= 400; i++) begin
            if (i == err_at) load_a(1'b0, 8'h30, 8'hAA, 1'b1);
            else drive_a(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
            n = i;
            if (ifa.ready_o === 1'b1) break;
        end
        check("a_ready_edges", n, exp_edges);
    endtask

    // ---------------- DUT B stimulus ----------------
    task automatic drive_b(input bit fe, input logic [1:0] fb, input logic [7:0] fa,
                           input bit le, input logic [1:0] lb, input logic [7:0] la,
                           input logic [7:0] ld, input bit xv, input logic [7:0] xd, input bit xe);
        exp_t e;
        ifb.fetch_req_i = fe;
        ifb.bank_sel_i  = fb;
        ifb.address_i   = fa;
        ifb.load_en_i   = le;
        ifb.load_bank_i = lb;
        ifb.load_addr_i = la;
        ifb.load_data_i = ld;
        if (xv) begin
            e.data = xd;
            e.cyc  = cycle_cnt + 1;
            qb.push_back(e);
        end
        if (xe) eb.push_back(cycle_cnt + 1);
        @(posedge clk);
        #1;
        ifb.fetch_req_i = 1'b0;
        ifb.load_en_i   = 1'b0;
    endtask

    task automatic idle_b();
        drive_b(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic fetch_b(input logic [1:0] b, input logic [7:0] a, input logic [7:0] xd);
        drive_b(1'b1, b, a, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, xd, 1'b0);
    endtask

    task automatic load_b(input logic [1:0] b, input logic [7:0] a, input logic [7:0] d, input bit xe);
        drive_b(1'b0, 2'd0, 8'h00, 1'b1, b, a, d, 1'b0, 8'h00, xe);
    endtask

    task automatic wait_ready_b(input int exp_edges, input int err_at);
        int n = 0;
        for (int i = 1; i <= 400; i++) begin
            if (i == err_at) load_b(2'd0, 8'h10, 8'hAA, 1'b1);
            else drive_b(1'b1, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
            n = i;
            if (ifb.ready_o === 1'b1) break;
        end
        check("b_ready_edges", n, exp_edges);
    endtask

    // ---------------- Monitors ----------------
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ifa.inst_valid_o === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_valid", 32'(ifa.inst_valid_o), 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_fetch_data", 32'(ifa.instruction_o), 32'(e.data));
                check("a_fetch_latency", cycle_cnt, e.cyc);
            end
        end else if (qa.size() > 0 && qa[0].cyc <= cycle_cnt) begin
            e = qa.pop_front();
            check("a_fetch_missing", 32'(ifa.inst_valid_o), 32'd1);
        end
        if (ifa.load_err_o === 1'b1) begin
            if (ea.size() == 0) check("a_unexpected_err", 32'(ifa.load_err_o), 32'd0);
            else check("a_err_cycle", cycle_cnt, ea.pop_front());
        end else if (ea.size() > 0 && ea[0] <= cycle_cnt) begin
            void'(ea.pop_front());
            check("a_err_missing", 32'(ifa.load_err_o), 32'd1);
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (ifb.inst_valid_o === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_valid", 32'(ifb.inst_valid_o), 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_fetch_data", 32'(ifb.instruction_o), 32'(e.data));
                check("b_fetch_latency", cycle_cnt, e.cyc);
            end
        end else if (qb.size() > 0 && qb[0].cyc <= cycle_cnt) begin
            e = qb.pop_front();
            check("b_fetch_missing", 32'(ifb.inst_valid_o), 32'd1);
        end
        if (ifb.load_err_o === 1'b1) begin
            if (eb.size() == 0) check("b_unexpected_err", 32'(ifb.load_err_o), 32'd0);
            else check("b_err_cycle", cycle_cnt, eb.pop_front());
        end else if (eb.size() > 0 && eb[0] <= cycle_cnt) begin
            void'(eb.pop_front());
            check("b_err_missing", 32'(ifb.load_err_o), 32'd1);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    // ---------------- Main sequence ----------------
    initial begin
        ifa.fetch_req_i = 1'b0; ifa.bank_sel_i = '0; ifa.address_i = '0;
        ifa.load_en_i = 1'b0; ifa.load_bank_i = '0; ifa.load_addr_i = '0; ifa.load_data_i = '0;
        ifb.fetch_req_i = 1'b0; ifb.bank_sel_i = '0; ifb.address_i = '0;
        ifb.load_en_i = 1'b0; ifb.load_bank_i = '0; ifb.load_addr_i = '0; ifb.load_data_i = '0;

        // Reset state, then CLEAR takes exactly 256 edges with fetches ignored.
        idle_a();
        idle_a();
        check("a_rst_ready", 32'(ifa.ready_o), 32'd0);
        check("a_rst_valid", 32'(ifa.inst_valid_o), 32'd0);
        check("a_rst_err", 32'(ifa.load_err_o), 32'd0);
        check("a_rst_inst", 32'(ifa.instruction_o), 32'(HALT));
        rst_a = 1'b1;
        wait_ready_a(256, 10);
        check("a_inst_hold_clear", 32'(ifa.instruction_o), 32'(HALT));
        fetch_a(1'b0, 8'h00, HALT);

        // Load two words and fetch them back to back.
        load_a(1'b0, 8'h00, 8'b11000000, 1'b0);
        load_a(1'b0, 8'h01, 8'b11000010, 1'b0);
        fetch_a(1'b0, 8'h00, 8'b11000000);
        fetch_a(1'b0, 8'h01, 8'b11000010);
        idle_a();
        check("a_idle_valid", 32'(ifa.inst_valid_o), 32'd0);
        check("a_idle_hold", 32'(ifa.instruction_o), 32'(8'b11000010));

        // Bank isolation.
        load_a(1'b1, 8'h05, 8'b00010001, 1'b0);
        fetch_a(1'b0, 8'h05, HALT);
        fetch_a(1'b1, 8'h05, 8'b00010001);

        // Read-first on same-cycle load and fetch of one location.
        load_a(1'b0, 8'h10, 8'b00011000, 1'b0);
        drive_a(1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 8'h10, 8'b00101000, 1'b1, 8'b00011000, 1'b0);
        fetch_a(1'b0, 8'h10, 8'b00101000);

        // Independent fetch and load to different locations in one cycle.
        drive_a(1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 8'h20, 8'h55, 1'b1, 8'b11000010, 1'b0);
        fetch_a(1'b1, 8'h20, 8'h55);
        fetch_a(1'b0, 8'h00, 8'b11000000);

        // Reset mid-READY, with a fetch presented on the reset edge.
        rst_a = 1'b0;
        drive_a(1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        check("a_rst2_ready", 32'(ifa.ready_o), 32'd0);
        check("a_rst2_valid", 32'(ifa.inst_valid_o), 32'd0);
        check("a_rst2_inst", 32'(ifa.instruction_o), 32'(HALT));
        rst_a = 1'b1;
        wait_ready_a(256, 20);
        fetch_a(1'b0, 8'h00, HALT);
        fetch_a(1'b0, 8'h01, HALT);
        fetch_a(1'b1, 8'h05, HALT);
        fetch_a(1'b0, 8'h10, HALT);
        fetch_a(1'b1, 8'h20, HALT);

        // Reset again, then a second reset 100 cycles into CLEAR.
        load_a(1'b0, 8'h00, 8'b11000000, 1'b0);
        rst_a = 1'b0;
        idle_a();
        rst_a = 1'b1;
        for (int i = 0; i < 100; i++) idle_a();
        rst_a = 1'b0;
        idle_a();
        check("a_rst3_ready", 32'(ifa.ready_o), 32'd0);
        check("a_rst3_valid", 32'(ifa.inst_valid_o), 32'd0);
        rst_a = 1'b1;
        wait_ready_a(256, 50);
        fetch_a(1'b0, 8'h00, HALT);
        idle_a();
        idle_a();

        // DUT B: DEPTH=96, NUM_BANKS=3.
        idle_b();
        check("b_rst_ready", 32'(ifb.ready_o), 32'd0);
        check("b_rst_inst", 32'(ifb.instruction_o), 32'(HALT));
        rst_b = 1'b1;
        wait_ready_b(96, 5);
        load_b(2'd0, 8'd95, 8'h77, 1'b0);
        fetch_b(2'd0, 8'd95, 8'h77);
        fetch_b(2'd0, 8'd96, HALT);
        fetch_b(2'd0, 8'd255, HALT);
        load_b(2'd0, 8'd100, 8'h33, 1'b1);
        fetch_b(2'd0, 8'd100, HALT);
        load_b(2'd0, 8'h85, 8'h34, 1'b1);
        fetch_b(2'd0, 8'h05, HALT);
        load_b(2'd3, 8'h05, 8'h99, 1'b1);
        load_b(2'd3, 8'h06, 8'h9A, 1'b1);
        fetch_b(2'd3, 8'h05, HALT);
        fetch_b(2'd1, 8'h05, HALT);
        load_b(2'd2, 8'h05, 8'h42, 1'b0);
        fetch_b(2'd2, 8'h05, 8'h42);
        fetch_b(2'd0, 8'd95, 8'h77);
        idle_b();
        idle_b();
        idle_a();

        check("a_queues_drained", 32'(qa.size() + ea.size()), 32'd0);
        check("b_queues_drained", 32'(qb.size() + eb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
